// File: rtl/smartbin_ctrl.sv
// smartbin_ctrl: level-driven pump sequencer. The su/lh/ll pins are synchronised and
// debounced, then a Moore FSM drives the motor, the level flags and the alarm.
// Ports: clk, rst_n (async, active-low); su/lh/ll raw pins (enable, high level, low level);
//        m motor run, fh filtered high, fl below-low flag, a alarm, st[1:0] state code.
// Optional: define SMARTBIN_MIN_OFF_EN to enforce MIN_OFF idle cycles after each fill.
module smartbin_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 200,
  parameter int MIN_OFF    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       su,
  input  logic       lh,
  input  logic       ll,
  output logic       m,
  output logic       fh,
  output logic       fl,
  output logic       a,
  output logic [1:0] st
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255 ||
      TIMEOUT < 1 || TIMEOUT > 65535 ||
      MIN_OFF < 0 || MIN_OFF > 65535) begin : g_bad_param
    $error("smartbin_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MON   = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  // bit 0 = su, bit 1 = lh, bit 2 = ll
  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] filt;

  assign raw = {ll, lh, su};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // The filter flips only after DEB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        filt[i] <= 1'b0;
      end else if (s2[i] == filt[i]) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt     <= '0;
        filt[i] <= s2[i];
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  logic su_f;
  logic lh_f;
  logic ll_f;
  logic inv;

  assign su_f = filt[0];
  assign lh_f = filt[1];
  assign ll_f = filt[2];
  assign inv  = lh_f & ~ll_f;

  state_t      state;
  state_t      state_n;
  logic [15:0] timer;
  logic [15:0] timer_n;
  logic        fill_ok;

`ifdef SMARTBIN_MIN_OFF_EN
  localparam logic [15:0] OFF_LOAD = 16'(MIN_OFF);

  logic [15:0] off;
  logic        load_off;

  assign fill_ok = (off == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off <= '0;
    end else if (state_n == IDLE) begin
      off <= '0;
    end else if (load_off) begin
      off <= OFF_LOAD;
    end else if (off != 16'd0) begin
      off <= off - 16'd1;
    end
  end
`else
  assign fill_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    timer_n = timer;
`ifdef SMARTBIN_MIN_OFF_EN
    load_off = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (su_f) state_n = MON;
      end
      MON: begin
        if (inv) begin
          state_n = FAULT;
        end else if (!su_f) begin
          state_n = IDLE;
        end else if (!ll_f && fill_ok) begin
          state_n = FILL;
          timer_n = '0;
        end
      end
      FILL: begin
        if (inv) begin
          state_n = FAULT;
        end else if (timer == TO_LAST && !lh_f) begin
          state_n = FAULT;
        end else if (lh_f) begin
          state_n = MON;
`ifdef SMARTBIN_MIN_OFF_EN
          load_off = 1'b1;
`endif
        end else if (!su_f) begin
          state_n = IDLE;
        end else if (timer != 16'hFFFF) begin
          timer_n = timer + 16'd1;
        end
      end
      FAULT: begin
        if (!su_f) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // Decoded from registers only, so reset clears m/a without waiting for a clock.
  assign m  = (state == FILL);
  assign a  = (state == FAULT);
  assign st = state;
  assign fh = lh_f;
  assign fl = ~ll_f;

endmodule

// File: doc/smartbin_ctrl.md
Name: smartbin_ctrl

Overview:
- Level-driven sequencer for the bin's pump/motor.
- Reads user enable (su) and high/low level sensors (lh, ll), synchronises and debounces them, and runs a Moore FSM that drives the motor, level flags and alarm.
- Sits between the raw ui_in sensor pins and the uo_out actuator pins in tt_um_SmartBing.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a filtered input updates (range 1..255).
- TIMEOUT, 200: maximum FILL duration in cycles before a fault (range 1..65535).
- MIN_OFF, 16: minimum motor-off cycles between runs (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- su  in  1  user enable, asynchronous pin, 1 = system armed
- lh  in  1  high-level sensor, asynchronous pin, 1 = level at/above high mark
- ll  in  1  low-level sensor, asynchronous pin, 1 = level at/above low mark
- m  out  1  motor drive, 1 = run
- fh  out  1  filtered lh
- fl  out  1  low flag = NOT filtered ll (level below low mark)
- a  out  1  alarm, 1 = FAULT state
- st  out  2  state code, for debug

Behaviour:
- Input conditioning:
  - Each of su/lh/ll passes through a 2-flop synchroniser, then a debounce counter.
  - The filtered bit updates when the synchronised value has differed from it for DEB_CYCLES consecutive cycles; any reversion clears the counter.
  - Pin change to filtered change = DEB_CYCLES+2 clocks. Pulses shorter than DEB_CYCLES cycles are ignored.
- Reset: asynchronous on rst_n=0.
  - Synchronisers and filters go to 0. State = IDLE (st=0). Timer = 0.
  - m=0, fh=0, fl=1, a=0.
  - Reset mid-FILL stops the motor immediately (asynchronously).
- State codes: IDLE=0, MON=1, FILL=2, FAULT=3.
- Outputs are decoded from registered state/filters only:
  - m = (state==FILL)
  - a = (state==FAULT)
  - st = state code
  - fh = lh_f; fl = ~ll_f
- Invalid sensor combination: inv = lh_f & ~ll_f.
- Transitions, evaluated each clock, first matching rule wins:
  - IDLE: su_f=1 -> MON. Otherwise stay.
  - MON:
    - inv -> FAULT
    - su_f=0 -> IDLE
    - ll_f=0 -> FILL, timer cleared to 0
  - FILL:
    - inv -> FAULT
    - timer==TIMEOUT-1 and lh_f=0 -> FAULT
    - lh_f=1 -> MON
    - su_f=0 -> IDLE
    - otherwise timer increments.
  - FAULT: latched. Exits only via su_f=0 -> IDLE; inv has no effect in this state.
- Priority: fault conditions beat su_f=0 on the same cycle.
- Timer: 16-bit, saturating, counts only in FILL. FILL lasts at most TIMEOUT cycles.
- Latency: filtered change -> state change -> m/a change on the next clock edge, 1 cycle.

Optional Feature:
- Macro SMARTBIN_MIN_OFF_EN.
- Defined:
  - On FILL->MON, an off-counter loads MIN_OFF and decrements each cycle down to 0.
  - MON->FILL is blocked while the off-counter is nonzero; the inv and su_f=0 transitions are unaffected.
  - The counter is cleared on reset and on entry to IDLE.
- Not defined: no off-counter logic exists, and FILL may re-enter on the cycle after MON entry.

Test Plan (DEB_CYCLES=4, TIMEOUT=50, MIN_OFF=16):
- Reset: rst_n=0 mid-FILL -> m=0 asynchronously, st=0, fl=1, a=0. Release rst_n with su=0 -> stays IDLE.
- Debounce: su=1, ll=1 held; 3-cycle ll=0 glitch -> no FILL, m stays 0. ll=0 held -> m=1 exactly DEB_CYCLES+3 = 7 clocks after the ll pin falls.
- Normal fill: in FILL, set ll=1 then lh=1 after 20 cycles -> fh=1, m=0 one clock later, st=1, a=0.
- Timeout: in FILL with lh held 0 -> st=3 and a=1 after exactly 50 FILL cycles. su=0 for ≥7 cycles -> st=0, a=0.
- Invalid sensors: in MON, lh=1 & ll=0 stable -> FAULT (a=1, m=0). Simultaneous su->0 on the same filtered cycle -> still FAULT.
- With SMARTBIN_MIN_OFF_EN: FILL ends, ll drops again immediately -> m stays 0 for 16 cycles, then FILL. Without the macro -> FILL resumes on the first eligible cycle.
